// File: rtl/riscv_core_rfwr_arb.sv
// riscv_core_rfwr_arb
//   Arbitrates the single rf_xpr write port between the in-order WB stage and a
//   long-latency unit. Late results that lose arbitration wait in a small FIFO.
//   A pending-register scoreboard supports decode hazard checks. If the FIFO head
//   keeps losing to WB, a registered stall forces the head onto the port.
// Ports
//   CLK, RST                     clock, synchronous active-high reset
//   wb_we/wb_wa/wb_d             WB stage write request
//   lu_valid/lu_wa/lu_d          late unit result, accepted when lu_ready
//   lu_ready                     late result can be accepted (FIFO not full)
//   sb_set/sb_set_wa             mark a register pending at late-op issue
//   sb_pending                   pending bitmap (bit 0 always 0)
//   rf_xpr_wrt0_WE/WA/D          register-file write port (combinational)
//   s_wb_stall_D                 registered stall request to the pipeline
module riscv_core_rfwr_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            wb_we,
  input  logic [4:0]      wb_wa,
  input  logic [XLEN-1:0] wb_d,
  input  logic            lu_valid,
  input  logic [4:0]      lu_wa,
  input  logic [XLEN-1:0] lu_d,
  output logic            lu_ready,
  input  logic            sb_set,
  input  logic [4:0]      sb_set_wa,
  output logic [31:0]     sb_pending,
  output logic            rf_xpr_wrt0_WE,
  output logic [4:0]      rf_xpr_wrt0_WA,
  output logic [XLEN-1:0] rf_xpr_wrt0_D,
  output logic            s_wb_stall_D
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [4:0]      r_fifo_wa [DEPTH];
  logic [XLEN-1:0] r_fifo_d  [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic            r_full;
  logic [31:0]     r_sb;
  logic [CW-1:0]   r_starve;
  logic            r_stall;

  logic            w_empty;
  logic            w_accept;
  logic            w_wb_go;
  logic            w_pop;
  logic            w_bypass;
  logic            w_push;
  logic [4:0]      w_late_wa;
  logic [31:0]     w_sb_next;

  assign w_empty  = (r_wr_ptr == r_rd_ptr) && !r_full;
  // A pop in the same cycle never frees a slot for this cycle's result.
  assign lu_ready = !RST && !r_full;
  assign w_accept = lu_valid && lu_ready;
  assign w_wb_go  = wb_we && (wb_wa != 5'd0);

  always_comb begin
    w_pop          = 1'b0;
    w_bypass       = 1'b0;
    rf_xpr_wrt0_WE = 1'b0;
    rf_xpr_wrt0_WA = '0;
    rf_xpr_wrt0_D  = '0;
    if (RST) begin
      w_pop = 1'b0;
    end else if (r_stall && !w_empty) begin
      w_pop = 1'b1;
    end else if (w_wb_go) begin
      rf_xpr_wrt0_WE = 1'b1;
      rf_xpr_wrt0_WA = wb_wa;
      rf_xpr_wrt0_D  = wb_d;
    end else if (!w_empty) begin
      w_pop = 1'b1;
    end else if (w_accept && (lu_wa != 5'd0)) begin
      w_bypass       = 1'b1;
      rf_xpr_wrt0_WE = 1'b1;
      rf_xpr_wrt0_WA = lu_wa;
      rf_xpr_wrt0_D  = lu_d;
    end
    if (w_pop) begin
      rf_xpr_wrt0_WE = 1'b1;
      rf_xpr_wrt0_WA = r_fifo_wa[r_rd_ptr];
      rf_xpr_wrt0_D  = r_fifo_d[r_rd_ptr];
    end
  end

  // Results for x0 are accepted but dropped.
  assign w_push    = w_accept && (lu_wa != 5'd0) && !w_bypass;
  assign w_late_wa = w_pop ? r_fifo_wa[r_rd_ptr] : lu_wa;

  // Set is applied after clear so a same-cycle set of the same bit wins.
  always_comb begin
    w_sb_next = r_sb;
    if (w_pop || w_bypass)
      w_sb_next[w_late_wa] = 1'b0;
    if (sb_set && (sb_set_wa != 5'd0))
      w_sb_next[sb_set_wa] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_wa[r_wr_ptr] <= lu_wa;
      r_fifo_d[r_wr_ptr]  <= lu_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_sb     <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop && ((r_wr_ptr + 1'b1) == r_rd_ptr))
        r_full <= 1'b1;
      else if (w_pop && !w_push)
        r_full <= 1'b0;

      r_sb <= w_sb_next;

      if (w_empty || w_pop)
        r_starve <= '0;
      else if (r_starve < CW'(STARVE_MAX))
        r_starve <= r_starve + 1'b1;

      if (r_stall && w_pop)
        r_stall <= 1'b0;
      else if (!w_empty && !w_pop && (r_starve >= CW'(STARVE_MAX - 1)))
        r_stall <= 1'b1;
    end
  end

  assign sb_pending   = r_sb;
  assign s_wb_stall_D = r_stall;

endmodule
